bus_arbiter: RTL and testbench

- Central arbiter for the serial system bus; shares one bus between MASTER_NUM master out-ports.
- Picks one requesting master using round-robin priority.
- Receives that master's serial slave-select bits and grants it the bus.
- Drives the master/slave routing selects for the bus mux and releases the bus when the transaction ends.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/rr_priority_picker.sv | 28 ++
 rtl/bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: arbiter state encoding, bus
// instruction codes and default field widths.
package bus_pkg;

  localparam int unsigned DefSlaveLen = 2;
  localparam int unsigned DefAddrLen  = 8;
  localparam int unsigned DefDataLen  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRxSelect,
    StCheck,
    StBusy,
    StRelease
  } arb_state_e;

  typedef enum logic [1:0] {
    InstrInactive = 2'b00,
    InstrWrite    = 2'b10,
    InstrRead     = 2'b11
  } bus_instr_e;

  typedef logic [DefAddrLen-1:0] bus_addr_t;
  typedef logic [DefDataLen-1:0] bus_data_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: returns the first requesting index strictly after
// last_winner, wrapping modulo MASTER_NUM, plus a valid flag.
module rr_priority_picker #(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned MSEL_W     = 1
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MSEL_W-1:0]     last_winner,
  output logic [MSEL_W-1:0]     winner,
  output logic                  valid
);

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = MASTER_NUM; k >= 1; k--) begin
      idx = (32'(last_winner) + k) % MASTER_NUM;
      if (req[idx[MSEL_W-1:0]]) begin
        winner = idx[MSEL_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central round-robin arbiter for the serial system bus. The winning master
// shifts in its slave select LSB first; the bus is granted once the target
// slave is ready and released when the owner reports completion.
// Optional watchdog: define ARB_TIMEOUT_EN to force a release after
// TIMEOUT_CYCLES cycles in BUSY and pulse timeout_err.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned SLAVE_LEN      = DefSlaveLen,
  parameter int unsigned MASTER_NUM     = 2,
  parameter int unsigned MSEL_W         = $clog2(MASTER_NUM),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [MASTER_NUM-1:0]   m_approval_request,
  input  logic [MASTER_NUM-1:0]   m_slave_select,
  input  logic [MASTER_NUM-1:0]   m_master_ready,
  output logic [MASTER_NUM-1:0]   m_arbitor_busy,
  output logic [MASTER_NUM-1:0]   m_approval_grant,
  input  logic [2**SLAVE_LEN-1:0] slave_ready,
  output logic                    bus_busy,
  output logic [MSEL_W-1:0]       master_sel,
  output logic [SLAVE_LEN-1:0]    slave_sel,
  output logic                    timeout_err
);

  localparam int unsigned CntW = $clog2(SLAVE_LEN + 1);

  if (MASTER_NUM < 2 || MASTER_NUM > 4 || MSEL_W != $clog2(MASTER_NUM) ||
      TIMEOUT_CYCLES < 3) begin : g_bad_params
    $error("bus_arbiter: illegal parameter combination");
  end

  arb_state_e              state_q, state_d;
  logic [MSEL_W-1:0]       owner_q, owner_d;
  logic [MSEL_W-1:0]       last_q, last_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [SLAVE_LEN-1:0]    sel_shift_q, sel_shift_d;
  logic [1:0]              hold_q, hold_d;
  logic                    bus_busy_q, bus_busy_d;
  logic [MSEL_W-1:0]       master_sel_q, master_sel_d;
  logic [SLAVE_LEN-1:0]    slave_sel_q, slave_sel_d;
  logic [MASTER_NUM-1:0]   grant_q, grant_d;
  logic [MSEL_W-1:0]       pick_winner;
  logic                    pick_valid;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TcntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TcntW-1:0]        tcnt_q, tcnt_d;
  logic                    tout_q, tout_d;
`endif

  rr_priority_picker #(
    .MASTER_NUM (MASTER_NUM),
    .MSEL_W     (MSEL_W)
  ) u_picker (
    .req         (m_approval_request),
    .last_winner (last_q),
    .winner      (pick_winner),
    .valid       (pick_valid)
  );

  // Next-state and registered-output logic for the arbitration sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    count_d      = count_q;
    sel_shift_d  = sel_shift_q;
    hold_d       = hold_q;
    bus_busy_d   = bus_busy_q;
    master_sel_d = master_sel_q;
    slave_sel_d  = slave_sel_q;
    grant_d      = '0;
`ifdef ARB_TIMEOUT_EN
    tcnt_d       = tcnt_q;
    tout_d       = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        count_d = '0;
        if (pick_valid) begin
          owner_d     = pick_winner;
          // Select bits arrive LSB first; shift in at the top so bit 0 lands at the bottom.
          sel_shift_d = SLAVE_LEN'(m_slave_select[pick_winner]) << (SLAVE_LEN - 1);
          if (SLAVE_LEN == 1) begin
            state_d = StCheck;
          end else begin
            state_d = StRxSelect;
            count_d = CntW'(1);
          end
        end
      end
      StRxSelect: begin
        if (!m_approval_request[owner_q]) begin
          // Owner abandoned the request; last_q is left alone.
          state_d = StIdle;
          count_d = '0;
        end else begin
          sel_shift_d = (sel_shift_q >> 1) |
                        (SLAVE_LEN'(m_slave_select[owner_q]) << (SLAVE_LEN - 1));
          count_d     = count_q + CntW'(1);
          if (count_q == CntW'(SLAVE_LEN - 1)) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (slave_ready[sel_shift_q] && !bus_busy_q) begin
          grant_d      = MASTER_NUM'(1) << owner_q;
          bus_busy_d   = 1'b1;
          master_sel_d = owner_q;
          slave_sel_d  = sel_shift_q;
          // Master still sits in its approval wait for two cycles after the grant.
          hold_d       = 2'd2;
          state_d      = StBusy;
`ifdef ARB_TIMEOUT_EN
          tcnt_d       = '0;
`endif
        end
      end
      StBusy: begin
        if (hold_q != 2'd0) begin
          hold_d = hold_q - 2'd1;
        end else if (m_master_ready[owner_q] && !m_approval_request[owner_q]) begin
          state_d = StRelease;
        end
`ifdef ARB_TIMEOUT_EN
        tcnt_d = tcnt_q + TcntW'(1);
        if (state_d == StBusy && tcnt_q == TcntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StRelease;
          tout_d  = 1'b1;
        end
`endif
      end
      StRelease: begin
        bus_busy_d = 1'b0;
        last_d     = owner_q;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_q       <= MSEL_W'(MASTER_NUM - 1);
      count_q      <= '0;
      sel_shift_q  <= '0;
      hold_q       <= '0;
      bus_busy_q   <= 1'b0;
      master_sel_q <= '0;
      slave_sel_q  <= '0;
      grant_q      <= '0;
`ifdef ARB_TIMEOUT_EN
      tcnt_q       <= '0;
      tout_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      count_q      <= count_d;
      sel_shift_q  <= sel_shift_d;
      hold_q       <= hold_d;
      bus_busy_q   <= bus_busy_d;
      master_sel_q <= master_sel_d;
      slave_sel_q  <= slave_sel_d;
      grant_q      <= grant_d;
`ifdef ARB_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
      tout_q       <= tout_d;
`endif
    end
  end

  // Busy indication: in IDLE only losing requesters, otherwise everyone but the owner.
  always_comb begin
    m_arbitor_busy = '0;
    if (state_q == StIdle) begin
      m_arbitor_busy = m_approval_request;
      if (pick_valid) begin
        m_arbitor_busy[pick_winner] = 1'b0;
      end
    end else begin
      m_arbitor_busy = ~(MASTER_NUM'(1) << owner_q);
    end
  end

  assign m_approval_grant = grant_q;
  assign bus_busy         = bus_busy_q;
  assign master_sel       = master_sel_q;
  assign slave_sel        = slave_sel_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err      = tout_q;
`else
  assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_bus_arbiter;

  localparam int unsigned SL = 2;
  localparam int unsigned NM = 3;
  localparam int unsigned MW = 2;
  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;

  localparam int PFree = 0, PCap = 1, PWait = 2, POwn = 3, PRel = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] req, sel, mrdy, arb_busy, grant;
  logic [NS-1:0] srdy;
  logic          bus_busy, tout;
  logic [MW-1:0] msel;
  logic [SL-1:0] ssel;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit model_on = 0;
  int ph, m_owner, m_last, m_age;
  int bits[$];
  int e_bus, e_msel, e_ssel, e_grant, e_tout;

  bus_arbiter #(
    .SLAVE_LEN      (SL),
    .MASTER_NUM     (NM),
    .MSEL_W         (MW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .m_approval_request (req),
    .m_slave_select     (sel),
    .m_master_ready     (mrdy),
    .m_arbitor_busy     (arb_busy),
    .m_approval_grant   (grant),
    .slave_ready        (srdy),
    .bus_busy           (bus_busy),
    .master_sel         (msel),
    .slave_sel          (ssel),
    .timeout_err        (tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NM-1:0] r, input int last);
    for (int k = 1; k <= NM; k++) begin
      int i;
      i = (last + k) % NM;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int exp_arb();
    logic [NM-1:0] v;
    int w;
    if (ph == PFree) begin
      v = req;
      w = rr_pick(req, m_last);
      if (w >= 0) v[w] = 1'b0;
    end else begin
      v = ~(NM'(1) << m_owner);
    end
    return int'(v);
  endfunction

  // One clock edge of the transaction-level model.
  task automatic model_step();
    int w, s;
    e_grant = 0;
    e_tout  = 0;
    if (!reset) begin
      ph = PFree; m_owner = 0; m_last = NM - 1; bits.delete();
      e_bus = 0; e_msel = 0; e_ssel = 0; model_on = 1;
      return;
    end
    if (!model_on) return;
    case (ph)
      PFree: begin
        w = rr_pick(req, m_last);
        if (w >= 0) begin
          m_owner = w;
          bits.delete();
          bits.push_back(int'(sel[w]));
          ph = (bits.size() == SL) ? PWait : PCap;
        end
      end
      PCap: begin
        if (!req[m_owner]) ph = PFree;
        else begin
          bits.push_back(int'(sel[m_owner]));
          if (bits.size() == SL) ph = PWait;
        end
      end
      PWait: begin
        s = 0;
        foreach (bits[i]) s += bits[i] << i;
        if (srdy[s] && e_bus == 0) begin
          e_grant = 1 << m_owner; e_bus = 1; e_msel = m_owner; e_ssel = s;
          m_age = 0; ph = POwn;
        end
      end
      POwn: begin
        m_age++;
        if (m_age > 2 && mrdy[m_owner] && !req[m_owner]) ph = PRel;
`ifdef ARB_TIMEOUT_EN
        else if (m_age == TO) begin
          ph = PRel; e_tout = 1;
        end
`endif
      end
      PRel: begin
        e_bus = 0; m_last = m_owner; ph = PFree;
      end
      default: ph = PFree;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      check("bus_busy", int'(bus_busy), e_bus);
      check("master_sel", int'(msel), e_msel);
      check("slave_sel", int'(ssel), e_ssel);
      check("grant", int'(grant), e_grant);
      check("timeout_err", int'(tout), e_tout);
      check("arbitor_busy", int'(arb_busy), exp_arb());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_grant(output int who, input int budget);
    who = -1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (grant != '0) begin
        for (int i = 0; i < NM; i++) if (grant[i]) who = i;
        return;
      end
    end
  endtask

  task automatic finish_txn(input int m);
    req[m]  = 1'b0;
    mrdy[m] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!bus_busy) break;
    end
    check("release", int'(bus_busy), 0);
    mrdy[m] = 1'b0;
  endtask

  initial begin
    int who, seen;
    req = '0; sel = '0; mrdy = '0; srdy = '1; reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    check("rst_bus_busy", int'(bus_busy), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_master_sel", int'(msel), 0);
    check("rst_slave_sel", int'(ssel), 0);
    check("rst_timeout", int'(tout), 0);

    // Single request to slave 1: select bits 1 then 0.
    req = 3'b001; sel = 3'b001;
    tick();
    #1 check("single_arb_busy0", int'(arb_busy[0]), 0);
    sel = 3'b000;
    tick();
    check("single_no_early_grant", int'(grant), 0);
    tick();
    check("single_grant", int'(grant), 1);
    check("single_bus_busy", int'(bus_busy), 1);
    check("single_slave_sel", int'(ssel), 1);
    check("single_master_sel", int'(msel), 0);
    tick();
    check("single_grant_pulse", int'(grant), 0);
    tick();
    req = 3'b000; mrdy = 3'b001;
    tick();
    check("single_busy_in_release", int'(bus_busy), 1);
    tick();
    check("single_bus_freed", int'(bus_busy), 0);
    mrdy = '0;

    // Contention between masters 0 and 1.
    do_reset();
    req = 3'b011; sel = 3'b001;
    #1 check("cont_arb_idle", int'(arb_busy), 3'b010);
    wait_grant(who, 10);
    check("cont_round1", who, 0);
    check("cont_arb_owned", int'(arb_busy), 3'b110);
    finish_txn(0);
    wait_grant(who, 10);
    check("cont_round2", who, 1);
    check("cont_round2_slave", int'(ssel), 0);
    req[0] = 1'b1;
    finish_txn(1);
    req[1] = 1'b1;
    wait_grant(who, 10);
    check("cont_round3", who, 0);
    finish_txn(0);
    req = '0;

    // Slave 3 not ready.
    do_reset();
    srdy = 4'b0111; req = 3'b001; sel = 3'b001;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (grant != '0) seen = 1;
    end
    check("nrdy_no_grant", seen, 0);
    srdy = 4'b1111;
    tick();
    check("nrdy_grant", int'(grant), 1);
    finish_txn(0);

    // Abandon after bit 0.
    do_reset();
    req = 3'b001; sel = 3'b000;
    tick();
    #1 check("abandon_arb_rx", int'(arb_busy), 3'b110);
    req = '0;
    tick();
    #1 check("abandon_arb_idle", int'(arb_busy), 0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (grant != '0 || bus_busy) seen = 1;
    end
    check("abandon_no_grant", seen, 0);

    // Reset in the middle of BUSY.
    do_reset();
    req = 3'b001; sel = 3'b001;
    wait_grant(who, 10);
    check("midrst_first", who, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("midrst_bus_busy", int'(bus_busy), 0);
    check("midrst_master_sel", int'(msel), 0);
    check("midrst_slave_sel", int'(ssel), 0);
    reset = 1'b1;
    req = 3'b010; sel = 3'b010;
    wait_grant(who, 10);
    check("midrst_regrant", who, 1);
    check("midrst_regrant_msel", int'(msel), 1);
    check("midrst_regrant_ssel", int'(ssel), 3);

    // Owner never completes.
    seen = 0;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < TO - 1; c++) begin
      tick();
      if (tout) seen = 1;
    end
    check("tout_early", seen, 0);
    tick();
    check("tout_pulse", int'(tout), 1);
    check("tout_busy_held", int'(bus_busy), 1);
    req = '0;
    tick();
    check("tout_bus_freed", int'(bus_busy), 0);
    check("tout_pulse_end", int'(tout), 0);
`else
    for (int c = 0; c < 2 * TO; c++) begin
      tick();
      if (tout) seen = 1;
    end
    check("tout_tied_low", seen, 0);
    check("tout_busy_held", int'(bus_busy), 1);
    finish_txn(1);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < NM; m++) begin
        if (req[m]) begin
          if ($urandom_range(7) == 0) req[m] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          req[m] = 1'b1;
        end
        sel[m]  = 1'($urandom_range(1));
        mrdy[m] = 1'($urandom_range(1));
      end
      for (int s = 0; s < NS; s++) srdy[s] = ($urandom_range(4) != 0);
      reset = ($urandom_range(499) != 0);
      tick();
    end
    reset = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
